// File: rtl/axis_packer.sv
// axis_packer: packs RATIO narrow beats into one registered wide word, with early partial flush.
// Define AXIS_PACKER_TIMEOUT_EN to also flush a partial word after TIMEOUT idle cycles.
module axis_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                            clock,
    input  logic                            resetn,
    input  logic [DATA_WIDTH-1:0]           idata,
    input  logic                            ivalid,
    output logic                            iready,
    input  logic                            flush,
    output logic [DATA_WIDTH*RATIO-1:0]     odata,
    output logic [$clog2(RATIO+1)-1:0]      ocount,
    output logic                            ovalid,
    input  logic                            oready
);
    localparam int W  = DATA_WIDTH * RATIO;
    localparam int FW = $clog2(RATIO);
    localparam int CW = $clog2(RATIO + 1);
    localparam logic [FW-1:0] LAST = FW'(RATIO - 1);
    logic [W-1:0]  acc, merged;
    logic [FW-1:0] fill;
    logic          pend, slot, acc_in, full, emit, timeout_hit;
    assign slot   = !ovalid || oready;
    assign iready = resetn && (fill < LAST || slot);
    assign acc_in = ivalid && iready;
    assign full   = acc_in && fill == LAST;
    assign emit   = full || ((flush || pend || timeout_hit) && slot && (fill != '0 || acc_in));
    // accumulator with this cycle's beat dropped into lane fill
    assign merged = acc | ((acc_in ? W'(idata) : '0) << (fill * DATA_WIDTH));
`ifdef AXIS_PACKER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer;
    assign timeout_hit = timer == TW'(TIMEOUT);
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            timer <= '0;
        else
            timer <= (acc_in || emit) ? '0 : (fill != '0 && !timeout_hit) ? timer + TW'(1) : timer;
    end
`else
    assign timeout_hit = 1'b0;
`endif
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            acc    <= '0;
            fill   <= '0;
            pend   <= 1'b0;
            odata  <= '0;
            ocount <= '0;
            ovalid <= 1'b0;
        end else begin
            if (emit) begin
                odata  <= merged;
                ocount <= full ? CW'(RATIO) : CW'(fill) + CW'(acc_in);
                ovalid <= 1'b1;
                acc    <= '0;
                fill   <= '0;
            end else begin
                ovalid <= ovalid && !oready;
                if (acc_in) begin
                    acc  <= merged;
                    fill <= fill + FW'(1);
                end
            end
            // a flush that cannot leave now waits for the output slot
            pend <= !emit && (pend || (flush && (fill != '0 || acc_in)));
        end
    end
endmodule

// File: tb/tb_axis_packer.sv
// tb_axis_packer: randomized and directed stimulus against a queue-based reference model,
// emitted words checked by a separate scoreboard monitor.
module tb_axis_packer;
    localparam int DW = 8;
    localparam int R  = 4;
    localparam int TO = 5;
    localparam int W  = DW * R;
    localparam int CW = $clog2(R + 1);
`ifdef AXIS_PACKER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0]  d;
        logic [CW-1:0] c;
    } word_t;

    logic          clock = 1'b0;
    logic          resetn;
    logic [DW-1:0] idata;
    logic          ivalid, iready, flush, ovalid, oready;
    logic [W-1:0]  odata;
    logic [CW-1:0] ocount;

    word_t         expq[$];
    logic [DW-1:0] beats[$];
    bit            m_ov, m_pend;
    int            idle;
    int            n_cmp = 0, n_bad = 0;
    word_t         mon_e;
    bit            held = 1'b0;
    logic [W-1:0]  hd;
    logic [CW-1:0] hc;

    int pv[6] = '{90, 50, 100, 30, 70, 95};
    int po[6] = '{100, 50, 30, 90, 10, 70};
    int pf[6] = '{0, 5, 10, 20, 2, 1};

    axis_packer #(.DATA_WIDTH(DW), .RATIO(R), .TIMEOUT(TO)) dut (
        .clock(clock), .resetn(resetn), .idata(idata), .ivalid(ivalid), .iready(iready),
        .flush(flush), .odata(odata), .ocount(ocount), .ovalid(ovalid), .oready(oready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: beats[] is the partial word, expq the words owed to the output
    task automatic step();
        bit slot, ir, acc, req, emit;
        logic [W-1:0] w;
        chk("ovalid", 64'(ovalid), 64'(m_ov));
        slot = !m_ov || oready;
        ir   = beats.size() < R - 1 || slot;
        chk("iready", 64'(iready), 64'(ir));
        acc  = ivalid && ir;
        req  = flush || m_pend || (TO_EN && idle >= TO);
        if (acc) beats.push_back(idata);
        emit = beats.size() == R || (req && slot && beats.size() > 0);
        if (emit) begin
            w = '0;
            foreach (beats[i]) w[i*DW +: DW] = beats[i];
            expq.push_back(word_t'{d: w, c: CW'(beats.size())});
            beats.delete();
            m_ov   = 1'b1;
            m_pend = 1'b0;
            idle   = 0;
        end else begin
            if (oready) m_ov = 1'b0;
            if (flush && beats.size() > 0) m_pend = 1'b1;
            if (acc) idle = 0;
            else if (beats.size() > 0) idle++;
        end
    endtask

    task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic fl, input logic ordy);
        ivalid = iv;
        idata  = d;
        flush  = fl;
        oready = ordy;
        @(negedge clock);
        step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        chk("rst_ovalid", 64'(ovalid), 64'd0);
        chk("rst_odata", 64'(odata), 64'd0);
        chk("rst_ocount", 64'(ocount), 64'd0);
        chk("rst_iready", 64'(iready), 64'd0);
        beats.delete();
        expq.delete();
        m_ov   = 1'b0;
        m_pend = 1'b0;
        idle   = 0;
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (!resetn) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("hold_odata", 64'(odata), 64'(hd));
                    chk("hold_ocount", 64'(ocount), 64'(hc));
                end
                if (ovalid && oready) begin
                    if (expq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_word: got %h/%0d expected none", odata, ocount);
                    end else begin
                        mon_e = expq.pop_front();
                        chk("odata", 64'(odata), 64'(mon_e.d));
                        chk("ocount", 64'(ocount), 64'(mon_e.c));
                    end
                end
                held = ovalid && !oready;
                hd   = odata;
                hc   = ocount;
            end
        end
    end

    initial begin
        ivalid = 1'b0;
        idata  = '0;
        flush  = 1'b0;
        oready = 1'b1;
        resetn = 1'b1;
        #2;
        do_reset();
        for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i * 17), 1'b0, 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, 8'hA1, 1'b0, 1'b1);
        cycle(1'b1, 8'hA2, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, 8'hC1, 1'b0, 1'b1);
        cycle(1'b1, 8'hC2, 1'b0, 1'b1);
        cycle(1'b1, 8'hC3, 1'b1, 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 1; i <= 7; i++) cycle(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'hD8, 1'b0, 1'b0);
        cycle(1'b1, 8'hD8, 1'b0, 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, 8'h7E, 1'b0, 1'b1);
        repeat (8) cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 1; i <= 6; i++) cycle(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
        do_reset();
        for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(8'hF0 + i), 1'b0, 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int p = 0; p < 6; p++)
            for (int k = 0; k < 400; k++)
                cycle($urandom_range(99) < pv[p], 8'($urandom), $urandom_range(99) < pf[p],
                      $urandom_range(99) < po[p]);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        repeat (4) cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("leftover_words", 64'(expq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
